control_sequencer: RTL and testbench

Two-phase fetch/execute sequencer for the nic8 datapath. It owns the 8-bit program counter and drives the 15-bit `Control` bundle consumed by the register file, bus and ALU. It is the producing end of that bundle: it decodes the IR the register file latched and reacts to the carry flag the register file holds. It also takes `dbus` so it can load the PC on jumps.

---
 rtl/control_sequencer.sv | 148 ++++++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Two-phase fetch/execute sequencer for the nic8 datapath: owns the PC and
// drives the Control bundle from the latched IR and the carry flag.
module control_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        resetB,
  input  logic [7:0]  ir,
  input  logic        flagCarry,
  input  logic [7:0]  dbus,
  output logic [14:0] controlBits,
  output logic [7:0]  pc,
  output logic [1:0]  phase,
  output logic        halted
);

  localparam int unsigned PC_W   = 8;
  localparam int unsigned CTRL_W = 15;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [2:0] DEST_A    = 3'd0;
  localparam logic [2:0] DEST_B    = 3'd1;
  localparam logic [2:0] DEST_X    = 3'd2;
  localparam logic [2:0] DEST_OUT  = 3'd3;
  localparam logic [2:0] DEST_MEM  = 3'd4;
  localparam logic [2:0] DEST_PC   = 3'd5;
  localparam logic [2:0] DEST_NOP  = 3'd6;
  localparam logic [2:0] DEST_HALT = 3'd7;

  localparam logic [1:0] SRC_M = 2'd0;
  localparam logic [1:0] SRC_E = 2'd1;
  localparam logic [1:0] SRC_A = 2'd2;
  localparam logic [1:0] SRC_X = 2'd3;

  typedef struct packed {
    logic loadIR;
    logic loadPC;
    logic loadA;
    logic loadB;
    logic loadX;
    logic doOut;
    logic storeMem;
    logic assertM;
    logic assertE;
    logic assertA;
    logic assertX;
    logic immediate;
    logic jumpControl;
    logic doSubtract;
    logic doJump;
  } control_t;

  logic [1:0]      state;
  logic [1:0]      stateNext;
  logic [PC_W-1:0] pcNext;
  control_t        ctrl;

  logic [2:0] dest;
  logic [1:0] src;
  logic       immBit;
  logic       subBit;
  logic       jcBit;
  logic       isNop;
  logic       jumpTaken;

  assign dest   = ir[7:5];
  assign src    = ir[4:3];
  assign immBit = ir[2];
  assign subBit = ir[1];
  assign jcBit  = ir[0];

  // Mem <= M has no meaningful bus transfer, so it collapses into a NOP.
  assign isNop     = (dest == DEST_NOP) || ((dest == DEST_MEM) && (src == SRC_M));
  assign jumpTaken = (dest == DEST_PC) && (!jcBit || flagCarry);

  // State, PC and halt flag registers.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      halted <= (stateNext == HALT);
    end
  end

  // Next-state, next-PC and control decode.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    ctrl      = '0;
    case (state)
      FETCH: begin
        ctrl.loadIR    = 1'b1;
        ctrl.assertM   = 1'b1;
        ctrl.immediate = 1'b1;
        pcNext         = pc + PC_W'(1);
        stateNext      = EXEC;
      end
      EXEC: begin
        stateNext = FETCH;
        if (dest == DEST_HALT) begin
          stateNext = HALT;
        end else if (isNop) begin
          if (immBit) pcNext = pc + PC_W'(1);
        end else begin
          case (src)
            SRC_M:   ctrl.assertM = 1'b1;
            SRC_E:   ctrl.assertE = 1'b1;
            SRC_A:   ctrl.assertA = 1'b1;
            SRC_X:   ctrl.assertX = 1'b1;
            default: ctrl.assertM = 1'b1;
          endcase
          ctrl.immediate   = immBit;
          ctrl.jumpControl = jcBit;
          ctrl.doSubtract  = subBit;
          case (dest)
            DEST_A:   ctrl.loadA    = 1'b1;
            DEST_B:   ctrl.loadB    = 1'b1;
            DEST_X:   ctrl.loadX    = 1'b1;
            DEST_OUT: ctrl.doOut    = 1'b1;
            DEST_MEM: ctrl.storeMem = 1'b1;
            DEST_PC: begin
              ctrl.doJump = jumpTaken;
              ctrl.loadPC = jumpTaken;
              // A not-taken jump only keeps the operand-addressing bits.
              if (!jumpTaken) ctrl.doSubtract = 1'b0;
            end
            default: ;
          endcase
          if (jumpTaken)   pcNext = dbus;
          else if (immBit) pcNext = pc + PC_W'(1);
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

  assign phase       = state;
  assign controlBits = resetB ? CTRL_W'(ctrl) : '0;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed test-plan cases followed
// by random instructions compared against an instruction-level reference model.
module tb_control_sequencer;

  localparam logic [7:0] RST_PC = 8'h00;

  logic        clk = 1'b0;
  logic        resetB;
  logic [7:0]  ir;
  logic        flagCarry;
  logic [7:0]  dbus;
  logic [14:0] controlBits;
  logic [7:0]  pc;
  logic [1:0]  phase;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 FETCH, 1 EXEC, 2 HALT.
  int         mPhase;
  logic [7:0] mPc;
  int         haltCycles;

  control_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetB(resetB), .ir(ir), .flagCarry(flagCarry), .dbus(dbus),
    .controlBits(controlBits), .pc(pc), .phase(phase), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected Control bundle; bit 14 is loadIR ... bit 0 is doJump.
  function automatic logic [14:0] expCtrl(input int ph, input logic [7:0] i, input logic c);
    logic [14:0] r;
    int d;
    int s;
    bit taken;
    r = '0;
    d = int'(i[7:5]);
    s = int'(i[4:3]);
    if (ph == 0) begin
      r[14] = 1'b1; r[7] = 1'b1; r[3] = 1'b1;
    end else if (ph == 1 && d != 6 && d != 7 && !(d == 4 && s == 0)) begin
      r[7 - s] = 1'b1;
      r[3] = i[2];
      r[2] = i[0];
      if (d <= 4) begin
        r[12 - d] = 1'b1;
        r[1] = i[1];
      end else begin
        taken = (i[0] == 1'b0) || c;
        r[13] = taken;
        r[0]  = taken;
        r[1]  = taken ? i[1] : 1'b0;
      end
    end
    return r;
  endfunction

  task automatic modelAdvance(input logic [7:0] i, input logic c, input logic [7:0] d);
    int dst;
    dst = int'(i[7:5]);
    case (mPhase)
      0: begin mPc = mPc + 8'd1; mPhase = 1; end
      1: begin
        if (dst == 7) mPhase = 2;
        else begin
          if (dst == 5 && (i[0] == 1'b0 || c)) mPc = d;
          else if (i[2]) mPc = mPc + 8'd1;
          mPhase = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkOutputs(input logic [7:0] i, input logic c);
    check("ctrl",   32'(controlBits), 32'(expCtrl(mPhase, i, c)));
    check("pc",     32'(pc),          32'(mPc));
    check("phase",  32'(phase),       32'(mPhase));
    check("halted", 32'(halted),      32'(mPhase == 2));
  endtask

  // One clock: drive on the falling edge, check, then let the rising edge commit.
  task automatic step(input logic [7:0] i, input logic c, input logic [7:0] d);
    @(negedge clk);
    ir = i; flagCarry = c; dbus = d;
    #1;
    checkOutputs(i, c);
    modelAdvance(i, c, d);
  endtask

  task automatic fetch();
    step(8'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetB = 1'b0;
    #1;
    check("rst_ctrl",   32'(controlBits), 32'(0));
    check("rst_pc",     32'(pc),          32'(RST_PC));
    check("rst_phase",  32'(phase),       32'(0));
    check("rst_halted", 32'(halted),      32'(0));
    mPc = RST_PC; mPhase = 0; haltCycles = 0;
    @(posedge clk);
    #1;
    resetB = 1'b1;
  endtask

  initial begin
    logic [7:0] ri;
    resetB = 1'b0; ir = 8'h00; flagCarry = 1'b0; dbus = 8'h00;
    mPc = RST_PC; mPhase = 0; haltCycles = 0;
    #12;
    check("init_ctrl", 32'(controlBits), 32'(0));
    check("init_pc",   32'(pc),          32'(RST_PC));
    @(posedge clk);
    #1;
    resetB = 1'b1;

    // A <= immediate M, then the conditional jump both ways.
    step(8'h04, 1'b0, 8'h00);
    step(8'h04, 1'b0, 8'h00);
    fetch(); step(8'hA1, 1'b0, 8'h40);
    fetch(); step(8'hA1, 1'b1, 8'h40);
    // Jump to FE; FETCH reaches FF; immediate jump at FF lands on 10.
    fetch(); step(8'hA0, 1'b0, 8'hFE);
    fetch(); step(8'hA4, 1'b0, 8'h10);
    // Jump to FF; FETCH there wraps to 00.
    fetch(); step(8'hA0, 1'b0, 8'hFF);
    fetch(); step(8'h80, 1'b0, 8'h00);
    check("wrap_pc", 32'(pc), 32'(8'h00));
    // Illegal Mem <= M, plain and with immediate.
    fetch(); step(8'h80, 1'b1, 8'h33);
    fetch(); step(8'h84, 1'b1, 8'h33);

    // Reset pulled low in the middle of EXEC of 8'h0C.
    fetch();
    @(negedge clk);
    ir = 8'h0C; flagCarry = 1'b0; dbus = 8'h00;
    #1;
    checkOutputs(8'h0C, 1'b0);
    #2;
    resetB = 1'b0;
    #1;
    check("abort_ctrl",  32'(controlBits), 32'(0));
    check("abort_pc",    32'(pc),          32'(RST_PC));
    check("abort_phase", 32'(phase),       32'(0));
    mPc = RST_PC; mPhase = 0;
    @(posedge clk);
    #1;
    check("abort_hold_pc", 32'(pc), 32'(RST_PC));
    resetB = 1'b1;

    // HALT is sticky for 20 cycles of arbitrary IR, then a reset recovers.
    fetch(); fetch(); fetch(); step(8'hFF, 1'b0, 8'h00);
    for (int n = 0; n < 20; n++) fetch();
    applyReset();
    fetch();

    // Random instruction stream; HALT made rare and cleared by reset.
    for (int n = 0; n < 600; n++) begin
      if (mPhase == 2) begin
        haltCycles++;
        if (haltCycles > 4) applyReset();
      end
      ri = 8'($urandom);
      if (ri[7:5] == 3'd7 && $urandom_range(0, 7) != 0) ri[7:5] = 3'd6;
      step(ri, 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
